regfile_multiport: RTL
======================

# regfile_multiport

Parametrised multi-port integer register file for the pipelined core, succeeding the single-write, two-read sequential-core register file. It provides:
- NUM_READ asynchronous read ports with same-cycle write-to-read bypass.
- NUM_WRITE synchronous write ports with fixed priority.
- A per-register busy scoreboard for hazard detection.
- A counter-driven clear sweep after reset, so contents are never undefined.

It sits between decode (reads, reservations) and writeback (writes).

## Interface
Parameters:
- XLEN, 64, register width in bits
- NREGS, 32, number of registers (power of two, ≥4); register 0 hardwired to zero
- NUM_READ, 2, number of read ports (1–4)
- NUM_WRITE, 2, number of write ports (1–2)
- AW, $clog2(NREGS), derived register-index width (localparam)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ready  out  1  high once the clear sweep has completed
- write_enable  in  NUM_WRITE  per-port write strobe
- rd  in  NUM_WRITE*AW  per-port destination index, port i at bits [i*AW +: AW]
- write_data  in  NUM_WRITE*XLEN  per-port write data
- rs  in  NUM_READ*AW  per-port source index
- read_data  out  NUM_READ*XLEN  per-port read data
- busy  out  NUM_READ  per-port scoreboard status of rs
- reserve_en  in  1  mark reserve_rd as having a pending producer
- reserve_rd  in  AW  register index to reserve

## Operation
States:
- CLEAR: entered on any cycle with reset=1.
  - Sweep counter clr_idx is set to 0 in the reset cycle.
  - Each non-reset cycle writes 0 to registers[clr_idx], then increments clr_idx.
  - After writing index NREGS-1, the block moves to RUN.
- RUN: normal operation.
  - State, clr_idx and busy are all reset synchronously.

In CLEAR:
- ready=0; read_data=0 and busy=0 on every port.
- write_enable and reserve_en are ignored.

Writes in RUN:
- Port i writes registers[rd_i] ← write_data_i at the clock edge if write_enable_i=1 and rd_i≠0.
- If both ports target the same rd in the same cycle, port NUM_WRITE-1 wins. The other write is dropped.

Reads in RUN (combinational):
- rs_j=0 → read_data_j=0.
- Else, if any enabled write port targets rs_j this cycle, read_data_j = that port's write_data (highest-index match wins).
- Else read_data_j = registers[rs_j].

Scoreboard (busy_bits[NREGS], bit 0 constant 0):
- reserve_en=1 and reserve_rd≠0 → set busy_bits[reserve_rd] at the edge.
- An enabled write to rd≠0 clears busy_bits[rd] at the edge.
- Reserve and write to the same index in the same cycle: reserve wins (bit ends set; the newer producer is pending).
- busy_j = busy_bits[rs_j] & ~(any enabled write this cycle targets rs_j), i.e. the bypass makes the value available now.
- busy_j is 0 when rs_j=0.

## Timing
- Reset values: ready=0, read_data=0, busy=0; all busy_bits=0; clr_idx=0.
- Clear latency: reset deasserted at edge E0; registers 0..NREGS-1 are cleared on edges E1..E_NREGS. ready=1 from the cycle after E_NREGS (NREGS cycles after reset low).
- Reset asserted mid-sweep or in RUN: return to CLEAR and restart the sweep from index 0. Partially written contents are overwritten by the sweep.
- Write latency: committed at the edge. A same-cycle read sees the new value through the bypass (0-cycle). The next cycle sees it from storage.
- Read ports are purely combinational from rs, write_enable, rd, write_data and stored state. There is no read latency.
- reserve_en → busy visible on a matching rs in the next cycle.

## Test plan
- Reset sweep, NREGS=32: hold reset 3 cycles, release → ready=0 for exactly 32 cycles, then 1. Read all 32 indices → 0. A write issued during the sweep has no effect.
- Write/read with bypass: write port0 rd=5 data=0xDEAD_BEEF, rs0=5 in the same cycle → read_data0=0xDEAD_BEEF combinationally. Next cycle with write_enable=0 → still 0xDEAD_BEEF.
- x0: write rd=0 data=0xFFFF… on both ports, reserve_rd=0 → read rs=0 returns 0 and busy=0.
- Write conflict: port0 rd=7 data=1 and port1 rd=7 data=2 in the same cycle → same-cycle read 2; next-cycle read 2.
- Scoreboard:
  - reserve rd=9 → next cycle busy=1 for rs=9.
  - Write rd=9 → busy=0 in that same cycle (bypass), and 0 afterwards.
  - Reserve rd=9 while writing rd=9 → busy=1 next cycle.
- Mid-sweep reset: reset at sweep index 10, release → ready rises exactly 32 cycles later. busy_bits set before reset read 0.

Source files
------------

// File: rtl/regfile_multiport_if.sv
// Bundle of the register-file access signals shared by decode (reads and
// reservations) and writeback (writes).
//   master : pipeline side; drives indices, write strobes/data, reservations
//   slave  : register file; drives ready, read_data and busy
// Vectors are flat: port i of a field occupies bits [i*W +: W].
interface regfile_multiport_if #(
  parameter int XLEN      = 64,
  parameter int NREGS     = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2
);
  localparam int AW = $clog2(NREGS);

  logic                        ready;
  logic [NUM_WRITE-1:0]        write_enable;
  logic [NUM_WRITE*AW-1:0]     rd;
  logic [NUM_WRITE*XLEN-1:0]   write_data;
  logic [NUM_READ*AW-1:0]      rs;
  logic [NUM_READ*XLEN-1:0]    read_data;
  logic [NUM_READ-1:0]         busy;
  logic                        reserve_en;
  logic [AW-1:0]               reserve_rd;

  modport master (
    input  ready, read_data, busy,
    output write_enable, rd, write_data, rs, reserve_en, reserve_rd
  );

  modport slave (
    output ready, read_data, busy,
    input  write_enable, rd, write_data, rs, reserve_en, reserve_rd
  );
endinterface

// File: rtl/regfile_multiport.sv
// Multi-port integer register file with write-to-read bypass, a per-register
// busy scoreboard and a post-reset clear sweep.
//   clk          : rising-edge clock
//   reset        : synchronous, active-high; restarts the clear sweep
//   bus (slave)  : ready, NUM_READ async read ports (read_data/busy from rs),
//                  NUM_WRITE write ports (highest index wins on conflict),
//                  one reservation port (reserve_en/reserve_rd)
// Register 0 reads as zero; its storage is only ever touched by the sweep.
module regfile_multiport #(
  parameter int XLEN      = 64,
  parameter int NREGS     = 32,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 2
) (
  input  logic              clk,
  input  logic              reset,
  regfile_multiport_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          clr_idx_q, clr_idx_d;
  logic                   ready_q, ready_d;
  logic [NREGS-1:0]       busy_q, busy_d;
  logic [XLEN-1:0]        regs_q [NREGS];
  logic [XLEN-1:0]        regs_d [NREGS];

  // Next-state: sweep in CLEAR, prioritized writes and scoreboard in RUN.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    regs_d    = regs_q;
    if (state_q == CLEAR) begin
      regs_d[clr_idx_q] = '0;
      clr_idx_d         = clr_idx_q + AW'(1);
      if (clr_idx_q == AW'(NREGS-1)) state_d = RUN;
    end else begin
      // Ascending loop: the later (higher-index) port overwrites earlier ones.
      for (int i = 0; i < NUM_WRITE; i++) begin
        if (bus.write_enable[i] && bus.rd[i*AW +: AW] != '0) begin
          regs_d[bus.rd[i*AW +: AW]] = bus.write_data[i*XLEN +: XLEN];
          busy_d[bus.rd[i*AW +: AW]] = 1'b0;
        end
      end
      // Reservation applied after write clears: a new producer stays pending.
      if (bus.reserve_en && bus.reserve_rd != '0) busy_d[bus.reserve_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      regs_q    <= regs_d;
    end
  end

  // Read ports: storage, overridden by any same-cycle write to the same index.
  always_comb begin
    bus.read_data = '0;
    bus.busy      = '0;
    for (int j = 0; j < NUM_READ; j++) begin
      logic [AW-1:0]   idx;
      logic [XLEN-1:0] val;
      logic            hit;
      idx = bus.rs[j*AW +: AW];
      val = regs_q[idx];
      hit = 1'b0;
      for (int i = 0; i < NUM_WRITE; i++) begin
        if (bus.write_enable[i] && bus.rd[i*AW +: AW] == idx) begin
          val = bus.write_data[i*XLEN +: XLEN];
          hit = 1'b1;
        end
      end
      if (state_q == RUN && idx != '0) begin
        bus.read_data[j*XLEN +: XLEN] = val;
        bus.busy[j]                   = busy_q[idx] & ~hit;
      end
    end
  end

  assign bus.ready = ready_q;

endmodule
